threshold_detector: RTL and testbench
=====================================

# threshold_detector

Parametrised, clocked successor to the team's 3-input "value greater than 5" comparator. It accepts a stream of WIDTH-bit unsigned samples and compares each one against programmable thresholds. A consecutive-sample debounce and a hysteresis band are applied before the registered flag changes state. It also produces rise/fall pulses and a saturating event counter, and sits between a sample source and any logic that needs a clean "above threshold" indication.

## Interface
Parameters:
- WIDTH, 3, sample and threshold width in bits (unsigned).
- CNT_W, 8, width of the debounce setting and the run counter.
- EVT_W, 16, width of the event counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_value carries a sample this cycle.
- in_value  input  WIDTH  sample, unsigned.
- thr_hi  input  WIDTH  upper threshold; a sample qualifies high when in_value > thr_hi (strict).
- thr_lo  input  WIDTH  lower threshold; a sample qualifies low when in_value <= min(thr_lo, thr_hi).
- debounce  input  CNT_W  consecutive qualifying valid samples needed to switch; 0 is treated as 1.
- clear  input  1  synchronous clear of event_count.
- answer  output  1  registered above-threshold flag.
- rise  output  1  one-cycle pulse when answer goes 0->1.
- fall  output  1  one-cycle pulse when answer goes 1->0.
- event_count  output  EVT_W  number of rises since reset/clear, saturating.

## Operation
- States: ST_LOW, ST_PEND_HI, ST_HIGH, ST_PEND_LO. answer = 1 in ST_HIGH and ST_PEND_LO.
- Cycles with in_valid = 0: state, run counter and outputs hold; rise/fall = 0.
- ST_LOW / ST_PEND_HI, valid sample:
  - qualifies high: run+1 >= eff_debounce -> ST_HIGH, run <= 0, rise = 1; otherwise -> ST_PEND_HI, run <= run+1.
  - not qualifying high: -> ST_LOW, run <= 0.
- ST_HIGH / ST_PEND_LO: mirror image using the low qualifier. On completing the debounce -> ST_LOW with fall = 1. A non-qualifying sample -> ST_HIGH, run <= 0.
- Samples between the thresholds (hysteresis band) are non-qualifying in both directions and reset any pending run.
- Thresholds and debounce are sampled live every cycle. A change mid-pending does not reset run; the new values apply from that cycle.
- Run counter saturates at 2^CNT_W-1 and never wraps.
- event_count increments on rise and saturates at 2^EVT_W-1. If clear and rise occur in the same cycle, clear wins: count becomes 0 and that rise is not counted.

## Timing
- Latency: a valid sample at edge k that completes the debounce updates answer and rise/fall at edge k, so they are visible during cycle k+1. event_count updates on the same edge.
- rise and fall are registered, exactly one cycle wide, and never asserted together.
- With debounce <= 1, back-to-back valid samples can toggle answer every cycle.
- Reset values: state ST_LOW, run 0, answer 0, rise 0, fall 0, event_count 0. Reset asserts immediately and asynchronously in any state, including mid-pending. After release, a full debounce run is required again.
- rst_n deassertion is synchronised externally.

## Structure
- Package threshold_detector_pkg holds the state enum typedef and the state encodings (ST_LOW, ST_PEND_HI, ST_HIGH, ST_PEND_LO).
- Sub-module sat_counter (parameter W; inc, clr, q; saturating) is instantiated twice: once as the run counter (clr on any non-qualifying valid sample or on a switch) and once as the event counter.
- The top level contains the comparators, the FSM and the pulse registers.

## Test plan
- WIDTH=3, thr_hi=5, thr_lo=5, debounce=1; sweep valid in_value 0..7, then back to 0 -> answer 1 only on the cycles after samples 6 and 7. One rise after 6, one fall after 0, event_count = 1. This reproduces the original >5 comparator behaviour.
- debounce=3, thr_hi=5; send 6, 6, (in_valid=0 for 2 cycles), 6 -> rise after the third valid sample. Separately send 6, 6, 2, 6 -> no rise; state ends in ST_PEND_HI with run=1.
- Hysteresis thr_hi=5, thr_lo=2, debounce=1; send 7, 4, 3, 2 -> answer rises after 7, stays 1 through 4 and 3, falls after 2.
- EVT_W=2; produce 4 rises -> event_count reads 1, 2, 3, 3. Assert clear in the same cycle as a 5th rise -> event_count = 0.
- Boundaries: debounce=0 behaves as 1. thr_lo=6 with thr_hi=4 uses an effective low threshold of 4, so the sequence 5, 5 stays high.
- Assert rst_n low mid ST_PEND_HI (debounce=4, two 7s sent) -> all outputs 0 immediately. After release, three 7s give no rise and the fourth gives a rise.

Source files
------------

// File: rtl/threshold_detector_pkg.sv
// Shared types for threshold_detector.
// Holds the detector state encoding and a small helper that tells which side of
// the hysteresis the FSM is on.
package threshold_detector_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_PEND_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_PEND_LO = 2'd3
  } state_e;

  // Returns 1 in the states where answer is asserted.
  function automatic logic is_high_side(input state_e s);
    return (s == ST_HIGH) || (s == ST_PEND_LO);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count up by one (held at all-ones once reached)
//   clr        : synchronous clear, has priority over inc
//   q          : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/threshold_detector.sv
// Debounced, hysteretic threshold detector for a stream of unsigned samples.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : in_value carries a sample this cycle
//   in_value     : sample
//   thr_hi       : sample qualifies high when in_value > thr_hi
//   thr_lo       : sample qualifies low when in_value <= min(thr_lo, thr_hi)
//   debounce     : consecutive qualifying samples needed to switch (0 acts as 1)
//   clear        : synchronous clear of event_count (wins over a same-cycle rise)
//   answer       : registered above-threshold flag
//   rise, fall   : one-cycle pulses on answer 0->1 / 1->0
//   event_count  : saturating number of rises since reset/clear
//   dbg_state    : current FSM state
//   dbg_run      : current debounce run length
module threshold_detector
  import threshold_detector_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8,
  parameter int EVT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic [WIDTH-1:0] thr_lo,
  input  logic [CNT_W-1:0] debounce,
  input  logic             clear,
  output logic             answer,
  output logic             rise,
  output logic             fall,
  output logic [EVT_W-1:0] event_count,
  output state_e           dbg_state,
  output logic [CNT_W-1:0] dbg_run
);

  state_e           state_q;
  logic             answer_q;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] run_q;

  logic [CNT_W-1:0] eff_deb;
  logic [WIDTH-1:0] lo_eff;
  logic [CNT_W:0]   run_p1;
  logic             qual_hi;
  logic             qual_lo;
  logic             high_side;
  logic             qual;
  logic             done;
  logic             run_inc;
  logic             run_clr;
  logic             evt_inc;

  always_comb begin
    eff_deb   = (debounce == '0) ? CNT_W'(1) : debounce;
    // An inverted threshold pair collapses the band to thr_hi.
    lo_eff    = (thr_lo < thr_hi) ? thr_lo : thr_hi;
    qual_hi   = in_value > thr_hi;
    qual_lo   = in_value <= lo_eff;
    high_side = is_high_side(state_q);
    qual      = high_side ? qual_lo : qual_hi;
    // One extra bit so a saturated run still compares as complete.
    run_p1    = {1'b0, run_q} + (CNT_W + 1)'(1);
    done      = in_valid && qual && (run_p1 >= {1'b0, eff_deb});
    run_inc   = in_valid && qual && !done;
    run_clr   = in_valid && (!qual || done);
    evt_inc   = done && !high_side;
  end

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run_inc),
    .clr   (run_clr),
    .q     (run_q)
  );

  sat_counter #(.W(EVT_W)) u_evt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (evt_inc),
    .clr   (clear),
    .q     (event_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOW;
      answer_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          ST_LOW, ST_PEND_HI: begin
            if (done) begin
              state_q  <= ST_HIGH;
              answer_q <= 1'b1;
              rise_q   <= 1'b1;
            end else if (qual) begin
              state_q <= ST_PEND_HI;
            end else begin
              state_q <= ST_LOW;
            end
          end
          default: begin
            if (done) begin
              state_q  <= ST_LOW;
              answer_q <= 1'b0;
              fall_q   <= 1'b1;
            end else if (qual) begin
              state_q <= ST_PEND_LO;
            end else begin
              state_q <= ST_HIGH;
            end
          end
        endcase
      end
    end
  end

  assign answer    = answer_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign dbg_state = state_q;
  assign dbg_run   = run_q;

endmodule

// File: tb/tb_threshold_detector.sv
// Directed bench for threshold_detector. Each driven cycle pushes the expected
// {answer, rise, fall, event_count} seen after that edge; a monitor pops and compares.
module tb_threshold_detector;
  import threshold_detector_pkg::*;

  localparam int WIDTH = 3;
  localparam int CNT_W = 8;
  localparam int EVT_W = 2;
  localparam int RW    = 3 + EVT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_value = '0;
  logic [WIDTH-1:0] thr_hi = '0;
  logic [WIDTH-1:0] thr_lo = '0;
  logic [CNT_W-1:0] debounce = '0;
  logic             clear = 1'b0;
  logic             answer;
  logic             rise;
  logic             fall;
  logic [EVT_W-1:0] event_count;
  state_e           dbg_state;
  logic [CNT_W-1:0] dbg_run;

  logic [RW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int resp_n = 0;

  // Clock / reset
  always #5 clk = ~clk;

  threshold_detector #(.WIDTH(WIDTH), .CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_value    (in_value),
    .thr_hi      (thr_hi),
    .thr_lo      (thr_lo),
    .debounce    (debounce),
    .clear       (clear),
    .answer      (answer),
    .rise        (rise),
    .fall        (fall),
    .event_count (event_count),
    .dbg_state   (dbg_state),
    .dbg_run     (dbg_run)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic cfg(input int hi, input int lo, input int deb);
    thr_hi   = WIDTH'(hi);
    thr_lo   = WIDTH'(lo);
    debounce = CNT_W'(deb);
  endtask

  task automatic drive(input logic v, input int val, input logic clr,
                       input logic ea, input logic er, input logic ef, input int ec);
    @(negedge clk);
    in_valid = v;
    in_value = WIDTH'(val);
    clear    = clr;
    exp_q.push_back({ea, er, ef, EVT_W'(ec)});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic vs(input int val, input logic ea, input logic er, input logic ef, input int ec);
    drive(1'b1, val, 1'b0, ea, er, ef, ec);
  endtask

  task automatic idle(input logic ea, input int ec);
    drive(1'b0, 0, 1'b0, ea, 1'b0, 1'b0, ec);
  endtask

  // Scoreboard monitor
  initial begin
    logic [RW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        resp_n++;
        check($sformatf("resp#%0d {ans,rise,fall,cnt}", resp_n),
              32'({answer, rise, fall, event_count}), 32'(e));
      end
    end
  end

  // Timeout guard
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    // Reset state
    #12;
    check("reset outputs", 32'({answer, rise, fall, event_count}), 32'(0));
    check("reset state", 32'(dbg_state), 32'(ST_LOW));
    @(negedge clk);
    rst_n = 1'b1;

    // Legacy >5 behaviour: sweep 0..7 then 0
    cfg(5, 5, 1);
    for (int i = 0; i < 8; i++) begin
      vs(i, i > 5, i == 6, 1'b0, (i >= 6) ? 1 : 0);
    end
    vs(0, 0, 0, 1, 1);

    // Debounce 3 with idle gap
    drive(1'b0, 0, 1'b1, 0, 0, 0, 0);
    cfg(5, 5, 3);
    vs(6, 0, 0, 0, 0);
    vs(6, 0, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);
    vs(6, 1, 1, 0, 1);
    vs(0, 1, 0, 0, 1);
    vs(0, 1, 0, 0, 1);
    vs(0, 0, 0, 1, 1);

    // Interrupted run: 6,6,2,6 leaves a run of one
    vs(6, 0, 0, 0, 1);
    vs(6, 0, 0, 0, 1);
    vs(2, 0, 0, 0, 1);
    vs(6, 0, 0, 0, 1);
    check("pend state", 32'(dbg_state), 32'(ST_PEND_HI));
    check("pend run", 32'(dbg_run), 32'(1));
    vs(6, 0, 0, 0, 1);
    vs(6, 1, 1, 0, 2);
    vs(0, 1, 0, 0, 2);
    vs(0, 1, 0, 0, 2);
    vs(0, 0, 0, 1, 2);

    // Hysteresis band
    cfg(5, 2, 1);
    vs(7, 1, 1, 0, 3);
    vs(4, 1, 0, 0, 3);
    vs(3, 1, 0, 0, 3);
    vs(2, 0, 0, 1, 3);

    // Event counter saturation, then clear beats a same-cycle rise
    drive(1'b0, 0, 1'b1, 0, 0, 0, 0);
    cfg(5, 5, 1);
    for (int k = 1; k <= 4; k++) begin
      vs(7, 1, 1, 0, (k > 3) ? 3 : k);
      vs(0, 0, 0, 1, (k > 3) ? 3 : k);
    end
    drive(1'b1, 7, 1'b1, 1, 1, 0, 0);
    vs(0, 0, 0, 1, 0);

    // debounce=0 acts as 1
    cfg(5, 5, 0);
    vs(6, 1, 1, 0, 1);
    vs(0, 0, 0, 1, 1);

    // Inverted thresholds: effective low threshold is thr_hi
    cfg(4, 6, 1);
    vs(5, 1, 1, 0, 2);
    vs(5, 1, 0, 0, 2);
    vs(5, 1, 0, 0, 2);
    vs(4, 0, 0, 1, 2);

    // Asynchronous reset mid-pending
    cfg(5, 5, 4);
    vs(7, 0, 0, 0, 2);
    vs(7, 0, 0, 0, 2);
    check("pre-reset state", 32'(dbg_state), 32'(ST_PEND_HI));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'({answer, rise, fall, event_count}), 32'(0));
    check("async reset state", 32'(dbg_state), 32'(ST_LOW));
    check("async reset run", 32'(dbg_run), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    vs(7, 0, 0, 0, 0);
    vs(7, 0, 0, 0, 0);
    vs(7, 0, 0, 0, 0);
    vs(7, 1, 1, 0, 1);

    @(posedge clk);
    #2;
    check("scoreboard drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
